inv_key_expansion: RTL and testbench

- Inverse AES-128 key schedule for the decryption datapath; the mirror of the forward key expansion.
- Accepts the round-10 key, which the forward expander produces as its final key.
- Emits the round keys in descending order (10, 9, …, 0), one per valid/ready beat, to the inverse-round datapath.
- The S-box is combinational, so each new key is derived in one cycle.

---
 rtl/inv_key_expansion_if.sv | 28 ++
 rtl/inv_key_expansion.sv | 118 +++++++++++
 tb/tb_inv_key_expansion.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/inv_key_expansion_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inv_key_expansion_if : start/key request plus valid/ready round-key stream   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface inv_key_expansion_if #(
    parameter int KEY_WIDTH = 128
);
    logic                 start_expansion;
    logic [KEY_WIDTH-1:0] last_key;
    logic                 key_ready;
    logic [KEY_WIDTH-1:0] next_key;
    logic                 key_valid;
    logic [3:0]           key_round;
    logic                 busy;
    logic                 finished_expansion;

    // master issues the request and consumes keys; slave is the expander
    modport master (
        output start_expansion, last_key, key_ready,
        input  next_key, key_valid, key_round, busy, finished_expansion
    );
    modport slave (
        input  start_expansion, last_key, key_ready,
        output next_key, key_valid, key_round, busy, finished_expansion
    );
endinterface
`default_nettype wire

// File: rtl/inv_key_expansion.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inv_key_expansion : AES-128 inverse key schedule, round 10 down to round 0 |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module inv_key_expansion #(
    parameter int NUM_ROUNDS = 10,
    parameter int KEY_WIDTH  = 128
) (
    input  logic                clk,
    input  logic                reset_n,
    inv_key_expansion_if.slave  kx
);
    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_EMIT = 1'b1;

    // Forward S-box, byte 0x00 at the MSB end
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [0:0]           state_q, state_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic [3:0]           round_q, round_d;

    logic [31:0]          w_w0, w_w1, w_w2, w_w3;
    logic [31:0]          w_p0, w_p1, w_p2, w_p3;
    logic [31:0]          w_rot, w_sub;
    logic [7:0]           w_rcon;
    logic [KEY_WIDTH-1:0] w_prev_key;

    assign {w_w0, w_w1, w_w2, w_w3} = key_q;
    assign w_p3  = w_w3 ^ w_w2;
    assign w_p2  = w_w2 ^ w_w1;
    assign w_p1  = w_w1 ^ w_w0;
    assign w_rot = {w_p3[23:0], w_p3[31:24]};

    // Table lookup: entry b sits at bit offset (255-b)*8, i.e. {~b, 3'b000}
    for (genvar g = 0; g < 4; g++) begin : g_sbox
        assign w_sub[8*g +: 8] = c_SBOX[{~w_rot[8*g +: 8], 3'b000} +: 8];
    end

    always_comb begin
        w_rcon = 8'h00;
        case (round_q)
            4'd10:   w_rcon = 8'h36;
            4'd9:    w_rcon = 8'h1b;
            4'd8:    w_rcon = 8'h80;
            4'd7:    w_rcon = 8'h40;
            4'd6:    w_rcon = 8'h20;
            4'd5:    w_rcon = 8'h10;
            4'd4:    w_rcon = 8'h08;
            4'd3:    w_rcon = 8'h04;
            4'd2:    w_rcon = 8'h02;
            4'd1:    w_rcon = 8'h01;
            default: w_rcon = 8'h00;
        endcase
    end

    assign w_p0       = w_w0 ^ w_sub ^ {w_rcon, 24'h000000};
    assign w_prev_key = {w_p0, w_p1, w_p2, w_p3};

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        if (state_q == c_IDLE) begin
            if (kx.start_expansion) begin
                key_d   = kx.last_key;
                round_d = 4'(NUM_ROUNDS);
                state_d = c_EMIT;
            end
        end else if (kx.key_ready) begin
            if (round_q == 4'd0) begin
                key_d   = '0;
                round_d = 4'd0;
                state_d = c_IDLE;
            end else begin
                key_d   = w_prev_key;
                round_d = round_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= c_IDLE;
            key_q   <= '0;
            round_q <= 4'd0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
        end
    end

    assign kx.key_valid          = (state_q == c_EMIT);
    assign kx.busy               = (state_q == c_EMIT);
    assign kx.next_key           = kx.key_valid ? key_q : '0;
    assign kx.key_round          = kx.key_valid ? round_q : 4'd0;
    assign kx.finished_expansion = kx.key_valid && (round_q == 4'd0);
endmodule
`default_nettype wire

// File: tb/tb_inv_key_expansion.sv
`default_nettype none
// Bench for inv_key_expansion: FIPS-197 A.1 key table, backpressure, aborts,
// back-to-back starts and a zero-key sweep checked against a forward schedule.
module tb_inv_key_expansion;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    inv_key_expansion_if #(.KEY_WIDTH(128)) kx();

    inv_key_expansion #(.NUM_ROUNDS(10), .KEY_WIDTH(128)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .kx      (kx)
    );

    typedef struct {
        logic [3:0]   round;
        logic [127:0] key;
        logic         fin;
    } vec_t;

    vec_t         a1[11];
    logic [127:0] zbeat[11];
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, 128'(kx.key_valid), 128'd0);
        chk({tag, ".busy"},  128'(kx.busy), 128'd0);
        chk({tag, ".key"},   kx.next_key, 128'd0);
        chk({tag, ".round"}, 128'(kx.key_round), 128'd0);
        chk({tag, ".fin"},   128'(kx.finished_expansion), 128'd0);
    endtask

    task automatic chk_beat(input string tag, input int i);
        chk({tag, ".valid"}, 128'(kx.key_valid), 128'd1);
        chk({tag, ".busy"},  128'(kx.busy), 128'd1);
        chk({tag, ".round"}, 128'(kx.key_round), 128'(a1[i].round));
        chk({tag, ".key"},   kx.next_key, a1[i].key);
        chk({tag, ".fin"},   128'(kx.finished_expansion), 128'(a1[i].fin));
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance
    task automatic begin_seq(input logic [127:0] k);
        kx.start_expansion = 1'b1;
        kx.last_key        = k;
        @(negedge clk);
        kx.start_expansion = 1'b0;
        kx.last_key        = ~k;
    endtask

    task automatic sweep(input string tag, input int stall1, input int stall2,
                         input bit start_mid, input bit start_end);
        kx.key_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            int r;
            r = 10 - i;
            chk_beat(tag, i);
            if (r == stall1 || r == stall2) begin
                kx.key_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk_beat({tag, ".stall"}, i);
                end
                kx.key_ready = 1'b1;
            end
            if (start_mid && r == 5) begin
                kx.start_expansion = 1'b1;
                kx.last_key        = '0;
            end
            if (start_end && r == 0) begin
                kx.start_expansion = 1'b1;
                kx.last_key        = {4{32'hdeadbeef}};
            end
            @(negedge clk);
            kx.start_expansion = 1'b0;
        end
        chk_idle({tag, ".end"});
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse and affine map, independent of any table
    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] r, base, e, v;
        r = 8'h01; base = x; e = 8'd254;
        for (int k = 0; k < 8; k++) begin
            if (e[k]) r = gmul(r, base);
            base = gmul(base, base);
        end
        v = r;
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
               {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] fwd(input logic [127:0] k, input int r);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc;
        case (r)
            1: rc = 8'h01;  2: rc = 8'h02;  3: rc = 8'h04;  4: rc = 8'h08;
            5: rc = 8'h10;  6: rc = 8'h20;  7: rc = 8'h40;  8: rc = 8'h80;
            9: rc = 8'h1b;  default: rc = 8'h36;
        endcase
        {w0, w1, w2, w3} = k;
        t  = {w3[23:0], w3[31:24]};
        t  = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    initial begin
        logic [127:0] k;
        a1[0]  = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0};
        a1[1]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e, 1'b0};
        a1[2]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f, 1'b0};
        a1[3]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f, 1'b0};
        a1[4]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd, 1'b0};
        a1[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc, 1'b0};
        a1[6]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00, 1'b0};
        a1[7]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b, 1'b0};
        a1[8]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f, 1'b0};
        a1[9]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b0};
        a1[10] = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1};

        // reset wins over a simultaneous start
        kx.start_expansion = 1'b1;
        kx.last_key        = a1[0].key;
        kx.key_ready       = 1'b0;
        reset_n            = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        kx.start_expansion = 1'b0;
        reset_n            = 1'b1;

        kx.key_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle("ready_idle");

        begin_seq(a1[0].key);
        sweep("a1", -1, -1, 1'b0, 1'b0);

        begin_seq(a1[0].key);
        sweep("bp", 7, 0, 1'b0, 1'b0);

        begin_seq(a1[0].key);
        sweep("busy_start", -1, -1, 1'b1, 1'b0);

        begin_seq(a1[0].key);
        sweep("b2b_a", -1, -1, 1'b0, 1'b1);
        begin_seq(a1[0].key);
        sweep("b2b_b", -1, -1, 1'b0, 1'b0);

        // asynchronous abort during the round-4 beat
        begin_seq(a1[0].key);
        kx.key_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort.round_pre", 128'(kx.key_round), 128'd4);
        #2 reset_n = 1'b0;
        #1 chk_idle("abort");
        @(negedge clk);
        chk_idle("abort_hold");
        reset_n = 1'b1;
        begin_seq(128'h00112233445566778899aabbccddeeff);
        chk("abort.new_valid", 128'(kx.key_valid), 128'd1);
        chk("abort.new_round", 128'(kx.key_round), 128'd10);
        chk("abort.new_key", kx.next_key, 128'h00112233445566778899aabbccddeeff);
        kx.key_ready = 1'b1;
        for (int n = 0; n < 20 && kx.busy; n++) @(negedge clk);
        chk("abort.drain_busy", 128'(kx.busy), 128'd0);

        // zero key, checked by re-expanding the round-0 output forward
        begin_seq('0);
        kx.key_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            chk("zero.valid", 128'(kx.key_valid), 128'd1);
            chk("zero.round", 128'(kx.key_round), 128'(10 - i));
            zbeat[10 - i] = kx.next_key;
            @(negedge clk);
        end
        chk_idle("zero.end");
        chk("zero.r9", zbeat[9], 128'h55636363000000000000000000000000);
        k = zbeat[0];
        for (int r = 1; r <= 10; r++) begin
            k = fwd(k, r);
            chk($sformatf("zero.fwd_r%0d", r), zbeat[r], k);
        end
        chk("zero.fwd_r10_is_zero", k, 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
